// File: rtl/wdt_kick_ctrl.sv
// wdt_kick_ctrl: register-bus front end for the system watchdog timer.
// Handles arm/kick/auto-kick, tracks elapsed time and logs timeouts.
module wdt_kick_ctrl #(
    parameter logic [31:0] KICK_KEY            = 32'h5AFE_C0DE,
    parameter logic [31:0] WARN_CYCLES         = 32'd400_000_000,
    parameter logic [31:0] DEFAULT_AUTO_PERIOD = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr_en,
    input  logic        reg_rd_en,
    input  logic [4:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_rd_valid,
    output logic        wdt_arm,
    output logic        wdt_kick,
    input  logic        wdt_timeout,
    output logic        irq_warn
);

    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_KICK    = 5'h04;
    localparam logic [4:0] A_PERIOD  = 5'h08;
    localparam logic [4:0] A_STATUS  = 5'h0C;
    localparam logic [4:0] A_ELAPSED = 5'h10;

    logic        arm;
    logic        auto_en;
    logic        lock;
    logic        warn_ie;
    logic [31:0] auto_period;
    logic [31:0] auto_cnt;
    logic [31:0] elapsed;
    logic        bad_key;
    logic        to_seen;
    logic [7:0]  to_cnt;
    logic        to_q;

    logic [4:0]  addr;
    logic        wr_ctrl;
    logic        wr_kick;
    logic        wr_period;
    logic        wr_status;
    logic        key_ok;
    logic        kick_man;
    logic        kick_auto;
    logic        kick_now;
    logic        bad_set;
    logic        to_rise;
    logic        warn;
    logic [31:0] rd_mux;

    assign addr      = reg_addr & 5'h1C;
    assign wr_ctrl   = reg_wr_en && (addr == A_CTRL);
    assign wr_kick   = reg_wr_en && (addr == A_KICK);
    assign wr_period = reg_wr_en && (addr == A_PERIOD);
    assign wr_status = reg_wr_en && (addr == A_STATUS);

    assign key_ok    = (reg_wdata == KICK_KEY);
    assign kick_man  = wr_kick && key_ok;
    assign bad_set   = wr_kick && !key_ok;
    assign kick_auto = arm && auto_en && (auto_period != 32'd0)
                       && (auto_cnt == auto_period - 32'd1);
    assign kick_now  = kick_man || kick_auto;

    assign to_rise   = wdt_timeout && !to_q;
    assign warn      = arm && (elapsed >= WARN_CYCLES);
    assign irq_warn  = warn && warn_ie;

    // Control register; once locked, ARM/AUTO_KICK/LOCK can only be set
    always_ff @(posedge clk) begin
        if (rst) begin
            arm     <= 1'b0;
            auto_en <= 1'b0;
            lock    <= 1'b0;
            warn_ie <= 1'b0;
        end else if (wr_ctrl) begin
            arm     <= lock ? (arm | reg_wdata[0]) : reg_wdata[0];
            auto_en <= lock ? (auto_en | reg_wdata[1]) : reg_wdata[1];
            lock    <= lock | reg_wdata[2];
            warn_ie <= reg_wdata[3];
        end
    end

    // Auto-kick period register and its free-running counter
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_period <= DEFAULT_AUTO_PERIOD;
            auto_cnt    <= 32'd0;
        end else begin
            if (wr_period) begin
                auto_period <= reg_wdata;
            end
            if (kick_now || !arm || !auto_en || wr_period) begin
                auto_cnt <= 32'd0;
            end else begin
                auto_cnt <= auto_cnt + 32'd1;
            end
        end
    end

    // Shadow of time since the last kick, saturating
    always_ff @(posedge clk) begin
        if (rst) begin
            elapsed <= 32'd0;
        end else if (!arm || kick_now || to_rise) begin
            elapsed <= 32'd0;
        end else if (elapsed != 32'hFFFF_FFFF) begin
            elapsed <= elapsed + 32'd1;
        end
    end

    // Sticky status bits and timeout log; a set event beats a W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            bad_key <= 1'b0;
            to_seen <= 1'b0;
            to_cnt  <= 8'd0;
            to_q    <= 1'b0;
        end else begin
            to_q    <= wdt_timeout;
            bad_key <= bad_set || (bad_key && !(wr_status && reg_wdata[2]));
            to_seen <= to_rise || (to_seen && !(wr_status && reg_wdata[3]));
            if (to_rise && (to_cnt != 8'hFF)) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end

    // Registered drives toward the timer
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_arm  <= 1'b0;
            wdt_kick <= 1'b0;
        end else begin
            wdt_arm  <= arm;
            wdt_kick <= kick_now;
        end
    end

    // Read data selection from pre-write register state
    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            A_CTRL:    rd_mux = {28'd0, warn_ie, lock, auto_en, arm};
            A_PERIOD:  rd_mux = auto_period;
            A_STATUS:  rd_mux = {16'd0, to_cnt, 4'd0,
                                 to_seen, bad_key, warn, arm};
            A_ELAPSED: rd_mux = elapsed;
            default:   rd_mux = 32'd0;
        endcase
    end

    // Registered read port; data holds between reads
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_rdata    <= 32'd0;
            reg_rd_valid <= 1'b0;
        end else begin
            reg_rd_valid <= reg_rd_en;
            if (reg_rd_en) begin
                reg_rdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_wdt_kick_ctrl.sv
// tb_wdt_kick_ctrl: randomized scenario bench for wdt_kick_ctrl.
// Expected values come from cycle counts and register rules.
module tb_wdt_kick_ctrl;

    localparam logic [31:0] KEY  = 32'h5AFE_C0DE;
    localparam logic [31:0] WARN = 32'd50;
    localparam logic [31:0] DEF  = 32'd100_000_000;

    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_KICK    = 5'h04;
    localparam logic [4:0] A_PERIOD  = 5'h08;
    localparam logic [4:0] A_STATUS  = 5'h0C;
    localparam logic [4:0] A_ELAPSED = 5'h10;

    logic        clk;
    logic        rst;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        reg_rd_valid;
    logic        wdt_arm;
    logic        wdt_kick;
    logic        wdt_timeout;
    logic        irq_warn;

    int total = 0;
    int bad   = 0;

    wdt_kick_ctrl #(
        .KICK_KEY(KEY),
        .WARN_CYCLES(WARN),
        .DEFAULT_AUTO_PERIOD(DEF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .reg_wr_en(reg_wr_en),
        .reg_rd_en(reg_rd_en),
        .reg_addr(reg_addr),
        .reg_wdata(reg_wdata),
        .reg_rdata(reg_rdata),
        .reg_rd_valid(reg_rd_valid),
        .wdt_arm(wdt_arm),
        .wdt_kick(wdt_kick),
        .wdt_timeout(wdt_timeout),
        .irq_warn(irq_warn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        reg_wr_en = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        @(negedge clk);
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d,
                      output logic v);
        reg_rd_en = 1'b1;
        reg_addr  = a;
        @(negedge clk);
        reg_rd_en = 1'b0;
        d = reg_rdata;
        v = reg_rd_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wdt_timeout = 1'b0;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic v;
        rst = 1'b1;
        idle(2);
        total++; if (wdt_arm !== 1'b0) begin bad++; $display("FAIL rst_arm got=%b exp=0", wdt_arm); end
        total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL rst_kick got=%b exp=0", wdt_kick); end
        total++; if (irq_warn !== 1'b0) begin bad++; $display("FAIL rst_irq got=%b exp=0", irq_warn); end
        total++; if (reg_rd_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", reg_rd_valid); end
        total++; if (reg_rdata !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", reg_rdata); end
        rst = 1'b0;
        rd(A_CTRL, d, v);
        total++; if (v !== 1'b1) begin bad++; $display("FAIL rst_rd_valid got=%b exp=1", v); end
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_ctrl got=%h exp=0", d); end
        rd(A_STATUS, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_status got=%h exp=0", d); end
        rd(A_ELAPSED, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_elapsed got=%h exp=0", d); end
        rd(A_PERIOD, d, v);
        total++; if (d !== DEF) begin bad++; $display("FAIL rst_period got=%h exp=%h", d, DEF); end
        idle(1);
        total++; if (reg_rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_drop got=%b exp=0", reg_rd_valid); end
        total++; if (reg_rdata !== DEF) begin bad++; $display("FAIL rdata_hold got=%h exp=%h", reg_rdata, DEF); end
    endtask

    task automatic test_arm_auto();
        int p;
        do_reset();
        wr(A_PERIOD, 32'd10);
        total++; if (wdt_arm !== 1'b0) begin bad++; $display("FAIL arm_pre got=%b exp=0", wdt_arm); end
        wr(A_CTRL, 32'h1);
        idle(1);
        total++; if (wdt_arm !== 1'b1) begin bad++; $display("FAIL arm_post got=%b exp=1", wdt_arm); end
        wr(A_CTRL, 32'h3);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            total++;
            if (wdt_kick !== ((k % 10) == 0)) begin
                bad++; $display("FAIL auto10 k=%0d got=%b exp=%b", k, wdt_kick, (k % 10) == 0);
            end
        end
        repeat (3) begin
            p = int'($urandom_range(1, 12));
            wr(A_PERIOD, p);
            for (int k = 1; k <= 3 * p; k++) begin
                @(negedge clk);
                total++;
                if (wdt_kick !== ((k % p) == 0)) begin
                    bad++; $display("FAIL auto_rand p=%0d k=%0d got=%b exp=%b", p, k, wdt_kick, (k % p) == 0);
                end
            end
        end
        wr(A_PERIOD, 32'd0);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL auto_zero k=%0d got=%b exp=0", k, wdt_kick); end
        end
    endtask

    task automatic test_manual_kick();
        logic [31:0] d;
        logic [31:0] v32;
        logic v;
        int n;
        do_reset();
        wr(A_CTRL, 32'h1);
        repeat (3) begin
            wr(A_KICK, KEY);
            total++; if (wdt_kick !== 1'b1) begin bad++; $display("FAIL kick_pulse got=%b exp=1", wdt_kick); end
            rd(A_ELAPSED, d, v);
            total++; if (d !== 32'd0) begin bad++; $display("FAIL kick_elapsed got=%0d exp=0", d); end
            total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL kick_width got=%b exp=0", wdt_kick); end
            n = int'($urandom_range(3, 20));
            idle(n);
            rd(A_ELAPSED, d, v);
            total++; if (d !== 32'(n + 1)) begin bad++; $display("FAIL elapsed_count got=%0d exp=%0d", d, n + 1); end
        end
        repeat (3) begin
            v32 = $urandom;
            if (v32 == KEY) v32 = v32 ^ 32'h1;
            wr(A_KICK, v32);
            total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL badkey_nokick got=%b exp=0", wdt_kick); end
            idle(1);
            total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL badkey_nokick2 got=%b exp=0", wdt_kick); end
            rd(A_STATUS, d, v);
            total++; if (d !== 32'h5) begin bad++; $display("FAIL badkey_status got=%h exp=5", d); end
            wr(A_STATUS, 32'h4);
            rd(A_STATUS, d, v);
            total++; if (d !== 32'h1) begin bad++; $display("FAIL badkey_w1c got=%h exp=1", d); end
        end
        rd(A_KICK, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL kick_reads0 got=%h exp=0", d); end
    endtask

    task automatic test_back_to_back();
        int p;
        do_reset();
        wr(A_CTRL, 32'h1);
        wr(A_KICK, KEY);
        total++; if (wdt_kick !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b exp=1", wdt_kick); end
        wr(A_KICK, KEY);
        total++; if (wdt_kick !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b exp=1", wdt_kick); end
        idle(1);
        total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b exp=0", wdt_kick); end
        p = int'($urandom_range(4, 10));
        wr(A_PERIOD, p);
        wr(A_CTRL, 32'h3);
        idle(p - 1);
        wr(A_KICK, KEY);
        total++; if (wdt_kick !== 1'b1) begin bad++; $display("FAIL both_pulse got=%b exp=1", wdt_kick); end
        for (int k = p + 1; k <= 2 * p; k++) begin
            @(negedge clk);
            total++;
            if (wdt_kick !== (k == 2 * p)) begin
                bad++; $display("FAIL both_after p=%0d k=%0d got=%b exp=%b", p, k, wdt_kick, k == 2 * p);
            end
        end
    endtask

    task automatic test_warn();
        logic [31:0] d;
        logic v;
        do_reset();
        wr(A_CTRL, 32'h9);
        for (int k = 1; k <= 55; k++) begin
            @(negedge clk);
            total++;
            if (irq_warn !== (32'(k) >= WARN)) begin
                bad++; $display("FAIL warn_rise k=%0d got=%b exp=%b", k, irq_warn, 32'(k) >= WARN);
            end
        end
        wr(A_KICK, KEY);
        total++; if (irq_warn !== 1'b0) begin bad++; $display("FAIL warn_kick got=%b exp=0", irq_warn); end
        wr(A_CTRL, 32'h1);
        idle(55);
        total++; if (irq_warn !== 1'b0) begin bad++; $display("FAIL warn_masked got=%b exp=0", irq_warn); end
        rd(A_STATUS, d, v);
        total++; if (d !== 32'h3) begin bad++; $display("FAIL warn_status got=%h exp=3", d); end
        wr(A_CTRL, 32'h9);
        total++; if (irq_warn !== 1'b1) begin bad++; $display("FAIL warn_unmask got=%b exp=1", irq_warn); end
    endtask

    task automatic test_lock();
        logic [31:0] d;
        logic [31:0] w;
        logic [3:0] m;
        logic v;
        do_reset();
        m = 4'h0;
        repeat (5) begin
            w = $urandom & 32'hFFFF_FFFB;
            wr(A_CTRL, w);
            m = {w[3], 1'b0, w[1:0]};
            rd(A_CTRL, d, v);
            total++; if (d !== {28'd0, m}) begin bad++; $display("FAIL ctrl_rw got=%h exp=%h", d, m); end
        end
        wr(A_CTRL, 32'h7);
        wr(A_CTRL, 32'h0);
        rd(A_CTRL, d, v);
        total++; if (d !== 32'h7) begin bad++; $display("FAIL lock_hold got=%h exp=7", d); end
        total++; if (wdt_arm !== 1'b1) begin bad++; $display("FAIL lock_arm got=%b exp=1", wdt_arm); end
        wr(A_CTRL, 32'hF);
        rd(A_CTRL, d, v);
        total++; if (d !== 32'hF) begin bad++; $display("FAIL lock_ie got=%h exp=f", d); end
        m = 4'hF;
        repeat (5) begin
            w = $urandom;
            wr(A_CTRL, w);
            m = {w[3], m[2:0] | w[2:0]};
            rd(A_CTRL, d, v);
            total++; if (d !== {28'd0, m}) begin bad++; $display("FAIL lock_rand got=%h exp=%h", d, m); end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        logic v;
        int cnt;
        int hi;
        int lo;
        do_reset();
        wr(A_CTRL, 32'h1);
        idle(10);
        repeat (2) begin
            wdt_timeout = 1'b1;
            idle(1);
            rd(A_ELAPSED, d, v);
            total++; if (d !== 32'd0) begin bad++; $display("FAIL to_elapsed got=%0d exp=0", d); end
            idle(3);
            wdt_timeout = 1'b0;
            idle(6);
        end
        rd(A_STATUS, d, v);
        total++; if (d !== 32'h209) begin bad++; $display("FAIL to_status2 got=%h exp=209", d); end
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, d, v);
        total++; if (d !== 32'h201) begin bad++; $display("FAIL to_w1c got=%h exp=201", d); end
        wdt_timeout = 1'b1;
        wr(A_STATUS, 32'h8);
        wdt_timeout = 1'b0;
        rd(A_STATUS, d, v);
        total++; if (d !== 32'h309) begin bad++; $display("FAIL to_setwins got=%h exp=309", d); end
        cnt = 3;
        for (int i = 1; i <= 300; i++) begin
            hi = int'($urandom_range(1, 3));
            lo = int'($urandom_range(1, 3));
            wdt_timeout = 1'b1;
            idle(hi);
            wdt_timeout = 1'b0;
            idle(lo);
            cnt = (cnt < 255) ? cnt + 1 : 255;
            if (i == 100 || i == 300) begin
                rd(A_STATUS, d, v);
                total++;
                if (d !== ((32'(cnt) << 8) | 32'h9)) begin
                    bad++; $display("FAIL to_cnt i=%0d got=%h exp=%h", i, d, (32'(cnt) << 8) | 32'h9);
                end
            end
        end
    endtask

    task automatic test_rw_same();
        logic [31:0] d;
        logic [31:0] a;
        logic [31:0] b;
        logic v;
        do_reset();
        a = $urandom;
        b = ~a;
        wr(A_PERIOD, a);
        reg_wr_en = 1'b1;
        reg_rd_en = 1'b1;
        reg_addr  = A_PERIOD;
        reg_wdata = b;
        @(negedge clk);
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        total++; if (reg_rdata !== a) begin bad++; $display("FAIL rw_pre got=%h exp=%h", reg_rdata, a); end
        rd(A_PERIOD, d, v);
        total++; if (d !== b) begin bad++; $display("FAIL rw_post got=%h exp=%h", d, b); end
        rd(5'h0B, d, v);
        total++; if (d !== b) begin bad++; $display("FAIL addr_lowbits got=%h exp=%h", d, b); end
        wr(5'h14, $urandom);
        rd(5'h14, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped got=%h exp=0", d); end
        rd(A_CTRL, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL unmapped_side got=%h exp=0", d); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [31:0] d;
        logic v;
        do_reset();
        wr(A_CTRL, 32'h1);
        wr(A_PERIOD, 32'd7);
        wr(A_KICK, KEY);
        total++; if (wdt_kick !== 1'b1) begin bad++; $display("FAIL mid_pulse got=%b exp=1", wdt_kick); end
        rst = 1'b1;
        idle(1);
        total++; if (wdt_kick !== 1'b0) begin bad++; $display("FAIL mid_kick got=%b exp=0", wdt_kick); end
        total++; if (wdt_arm !== 1'b0) begin bad++; $display("FAIL mid_arm got=%b exp=0", wdt_arm); end
        rst = 1'b0;
        rd(A_CTRL, d, v);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL mid_ctrl got=%h exp=0", d); end
        rd(A_PERIOD, d, v);
        total++; if (d !== DEF) begin bad++; $display("FAIL mid_period got=%h exp=%h", d, DEF); end
    endtask

    initial begin
        rst = 1'b1;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        reg_addr = 5'd0;
        reg_wdata = 32'd0;
        wdt_timeout = 1'b0;
        @(negedge clk);
        test_reset();
        test_arm_auto();
        test_manual_kick();
        test_back_to_back();
        test_warn();
        test_lock();
        test_timeout();
        test_rw_same();
        test_reset_mid_pulse();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wdt_kick_ctrl.md
# wdt_kick_ctrl

CPU-facing watchdog controller that drives the watchdog timer's arm and kick inputs. It sits between the Ariane register bus and the system watchdog timer. Firmware arms the watchdog, kicks it with a keyed write, or enables a hardware auto-kick. The block mirrors elapsed time since the last kick to raise a pre-timeout warning, and logs timeout events reported back by the timer.

## Interface
- KICK_KEY, 32'h5AFE_C0DE: value that must be written to KICK to generate a kick
- WARN_CYCLES, 400_000_000: elapsed cycles without a kick at which warning asserts
- DEFAULT_AUTO_PERIOD, 100_000_000: reset value of AUTO_PERIOD
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- reg_wr_en  in  1  write strobe, one cycle per access
- reg_rd_en  in  1  read strobe, one cycle per access
- reg_addr  in  5  byte address (word aligned; bits[1:0] ignored)
- reg_wdata  in  32  write data
- reg_rdata  out  32  read data
- reg_rd_valid  out  1  read data valid
- wdt_arm  out  1  level, to timer counter-start input
- wdt_kick  out  1  single-cycle pulse, to timer watchdog input
- wdt_timeout  in  1  timer reset output
- irq_warn  out  1  level interrupt: warning active and enabled

## Operation
- Registers:
  - 0x00 CTRL, RW:
    - bit0 ARM
    - bit1 AUTO_KICK
    - bit2 LOCK (set-only until rst)
    - bit3 WARN_IE
  - 0x04 KICK, WO: a write of KICK_KEY produces a kick. Any other value sets BAD_KEY and produces no kick. Reads as 0.
  - 0x08 AUTO_PERIOD, RW, 32-bit: cycles between auto kicks. 0 means no auto kicks are generated.
  - 0x0C STATUS:
    - bit0 armed (RO)
    - bit1 WARN (RO)
    - bit2 BAD_KEY (W1C)
    - bit3 TIMEOUT_SEEN (W1C)
    - bits[15:8] TIMEOUT_CNT (RO, saturates at 255)
    - other bits 0
  - 0x10 ELAPSED, RO: shadow counter value.
  - Any other address: reads 0, writes ignored.
- LOCK:
  - When LOCK=1, writes cannot clear ARM, AUTO_KICK or LOCK.
  - WARN_IE remains writable.
- Kick sources, ORed:
  - a valid KICK write;
  - an auto-kick (ARM=1, AUTO_KICK=1, AUTO_PERIOD≠0, auto counter reaches AUTO_PERIOD−1).
  - A kick while ARM=0 is accepted but has no effect on the timer.
- Auto counter:
  - Cleared on any kick and when ARM or AUTO_KICK is 0; otherwise increments.
  - A write to AUTO_PERIOD clears it.
- ELAPSED:
  - 32-bit. Cleared on any kick, when ARM=0, and on a wdt_timeout rising edge.
  - Otherwise increments while ARM=1, saturating at 32'hFFFF_FFFF.
- WARN = ARM & (ELAPSED ≥ WARN_CYCLES). irq_warn = WARN & WARN_IE.
- wdt_timeout rising edge:
  - sets TIMEOUT_SEEN;
  - increments TIMEOUT_CNT (saturating);
  - clears ELAPSED.
  - A level held high counts once.

## Timing
- Reset values:
  - wdt_arm=0, wdt_kick=0, irq_warn=0
  - reg_rdata=0, reg_rd_valid=0
  - CTRL=0, AUTO_PERIOD=DEFAULT_AUTO_PERIOD
  - STATUS sticky bits and TIMEOUT_CNT = 0
  - ELAPSED=0, auto counter=0
  - wdt_timeout edge detector = 0
- Register writes update state on the clk edge of the strobe. wdt_arm follows CTRL.ARM one cycle after the write edge (registered).
- wdt_kick is registered: high exactly one cycle, the cycle after the accepting KICK write edge or the auto-counter terminal edge. Simultaneous manual and auto kick give one pulse. Back-to-back valid KICK writes give back-to-back pulses.
- In the kick cycle, ELAPSED reads 0 on the following cycle.
- Reads: reg_rd_valid is high for one cycle, the cycle after reg_rd_en, with reg_rdata registered. reg_rdata holds its value otherwise.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- Simultaneous W1C and a set event for the same bit (bad key or timeout edge): set wins.
- rst mid-operation (including mid-pulse): all state returns to reset values on the next edge; wdt_kick drops immediately on that edge.

## Test plan
- Arm and auto-kick:
  - Stimulus: rst, then write CTRL=0x1, then CTRL=0x3 with AUTO_PERIOD=10.
  - Response: wdt_arm=1 one cycle after the first write; wdt_kick pulses every 10 cycles, one cycle wide.
- Manual kick key check:
  - Write KICK=0x5AFE_C0DE → one kick pulse, ELAPSED returns 0.
  - Write KICK=0x1234 → no pulse; STATUS bit2=1. Write STATUS=0x4 → bit2=0.
- Warning (WARN_CYCLES=50, ARM=1, WARN_IE=1, no kicks):
  - irq_warn rises when ELAPSED=50.
  - A valid kick drops irq_warn the next cycle.
- Lock:
  - Write CTRL=0x7, then CTRL=0x0 → CTRL reads 0x7 and wdt_arm stays 1.
  - Write CTRL=0xF → WARN_IE=1.
- Timeout logging:
  - Hold wdt_timeout high 5 cycles, twice, separated by low.
  - Response: TIMEOUT_CNT=2, TIMEOUT_SEEN=1, ELAPSED cleared at each rising edge.
  - 300 pulses → TIMEOUT_CNT=255.
- Reset mid-pulse: assert rst in the wdt_kick cycle → wdt_kick=0, CTRL=0 and AUTO_PERIOD=DEFAULT_AUTO_PERIOD on the next edge.
